// File: rtl/bip_exec_ctrl.sv
// bip_exec_ctrl: run/step/halt sequencer for the BIP CPU. It gates the CPU
// clock enable, counts enabled cycles, and lets a host access the data RAM
// while the CPU is not executing.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | CPU parked, waiting for i_start / i_step; host may use RAM
// RUN   | free-running until an HLT opcode is fetched
// STEP  | exactly one enabled cycle, then back to IDLE (or HALT on HLT)
// HALT  | HLT reached; only i_clear leaves, pulsing o_cpu_clr
module bip_exec_ctrl #(
  parameter int NB_INSTRUC = 16,
  parameter int NB_OPCODE  = 5,
  parameter int NB_ADDR    = 11,
  parameter int NB_DATA    = 16,
  parameter int NB_CYC     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_step,
  input  logic                  i_clear,
  input  logic [NB_INSTRUC-1:0] i_instruc,
  input  logic [NB_ADDR-1:0]    i_cpu_addr,
  input  logic [NB_DATA-1:0]    i_cpu_wdata,
  input  logic                  i_cpu_wr,
  input  logic                  i_cpu_rd,
  input  logic                  i_host_req,
  input  logic                  i_host_we,
  input  logic [NB_ADDR-1:0]    i_host_addr,
  input  logic [NB_DATA-1:0]    i_host_wdata,
  input  logic [NB_DATA-1:0]    i_ram_rdata,
  output logic                  o_cpu_en,
  output logic                  o_cpu_clr,
  output logic [NB_ADDR-1:0]    o_ram_addr,
  output logic [NB_DATA-1:0]    o_ram_wdata,
  output logic                  o_ram_we,
  output logic                  o_ram_re,
  output logic                  o_host_ack,
  output logic [NB_DATA-1:0]    o_host_rdata,
  output logic [1:0]            o_state,
  output logic [NB_CYC-1:0]     o_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  localparam logic [NB_CYC-1:0] CYC_ONE = {{(NB_CYC-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [NB_CYC-1:0]   cycles_q, cycles_d;
  logic                host_ack_q, host_ack_d;
  logic                cpu_clr_q, cpu_clr_d;
  logic                hlt;
  logic                cpu_en;
  logic                next_busy;
  logic                host_issue;
  logic                unused_instruc;

  // Only the opcode field matters; the operand bits are deliberately ignored.
  assign unused_instruc = ^i_instruc;

  assign hlt    = (i_instruc[NB_INSTRUC-1 -: NB_OPCODE] == '0);
  assign cpu_en = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !hlt;

  // Next-state logic; o_cpu_clr is registered so it lands in the cycle after i_clear.
  always_comb begin
    state_d   = state_q;
    cpu_clr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start)     state_d = ST_RUN;
        else if (i_step) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (hlt) state_d = ST_HALT;
      end
      ST_STEP: begin
        if (hlt) state_d = ST_HALT;
        else     state_d = ST_IDLE;
      end
      ST_HALT: begin
        if (i_clear) begin
          state_d   = ST_IDLE;
          cpu_clr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Enabled-cycle counter: saturating, cleared when leaving HALT.
  always_comb begin
    cycles_d = cycles_q;
    if ((state_q == ST_HALT) && i_clear)
      cycles_d = '0;
    else if (cpu_en && (cycles_q != '1))
      cycles_d = cycles_q + CYC_ONE;
  end

  // Host gets the RAM only when the CPU is idle now and will not start next
  // cycle; the ack cycle itself issues nothing, giving one access per two
  // cycles. Reset also blocks issue so the strobes are quiet while held.
  assign next_busy  = (state_d == ST_RUN) || (state_d == ST_STEP);
  assign host_issue = i_rst && !cpu_en && i_host_req && !host_ack_q && !next_busy;
  assign host_ack_d = host_issue;

  // RAM port mux: CPU first, then an issued host access, else quiet.
  always_comb begin
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    o_ram_we    = 1'b0;
    o_ram_re    = 1'b0;
    if (cpu_en) begin
      o_ram_addr  = i_cpu_addr;
      o_ram_wdata = i_cpu_wdata;
      o_ram_we    = i_cpu_wr;
      o_ram_re    = i_cpu_rd;
    end else if (host_issue) begin
      o_ram_addr  = i_host_addr;
      o_ram_wdata = i_host_wdata;
      o_ram_we    = i_host_we;
      o_ram_re    = !i_host_we;
    end
  end

  // State, counter and pulse registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      cycles_q   <= '0;
      host_ack_q <= 1'b0;
      cpu_clr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycles_q   <= cycles_d;
      host_ack_q <= host_ack_d;
      cpu_clr_q  <= cpu_clr_d;
    end
  end

  // RAM data arrives one cycle after the read, i.e. in the ack cycle.
  assign o_host_rdata = host_ack_q ? i_ram_rdata : '0;
  assign o_host_ack   = host_ack_q;
  assign o_cpu_clr    = cpu_clr_q;
  assign o_cpu_en     = cpu_en;
  assign o_state      = state_q;
  assign o_cycles     = cycles_q;

endmodule

// File: tb/tb_bip_exec_ctrl.sv
// Directed bench for bip_exec_ctrl with a small synchronous RAM model.
// A second instance with a 4-bit cycle counter exercises saturation.
module tb_bip_exec_ctrl;

  localparam logic [15:0] NOP = 16'h0800;
  localparam logic [15:0] HLT = 16'h0000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start, i_step, i_clear;
  logic [15:0] i_instruc;
  logic [10:0] i_cpu_addr;
  logic [15:0] i_cpu_wdata;
  logic        i_cpu_wr, i_cpu_rd;
  logic        i_host_req, i_host_we;
  logic [10:0] i_host_addr;
  logic [15:0] i_host_wdata;
  logic [15:0] i_ram_rdata;

  logic        o_cpu_en, o_cpu_clr, o_ram_we, o_ram_re, o_host_ack;
  logic [10:0] o_ram_addr;
  logic [15:0] o_ram_wdata, o_host_rdata;
  logic [1:0]  o_state;
  logic [15:0] o_cycles;

  logic        s_cpu_en, s_cpu_clr, s_ram_we, s_ram_re, s_host_ack;
  logic [10:0] s_ram_addr;
  logic [15:0] s_ram_wdata, s_host_rdata;
  logic [1:0]  s_state;
  logic [3:0]  s_cycles;

  logic [15:0] mem [0:2047];

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  bip_exec_ctrl u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_step(i_step), .i_clear(i_clear),
    .i_instruc(i_instruc), .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
    .i_cpu_wr(i_cpu_wr), .i_cpu_rd(i_cpu_rd), .i_host_req(i_host_req), .i_host_we(i_host_we),
    .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata), .i_ram_rdata(i_ram_rdata),
    .o_cpu_en(o_cpu_en), .o_cpu_clr(o_cpu_clr), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .o_ram_we(o_ram_we), .o_ram_re(o_ram_re),
    .o_host_ack(o_host_ack), .o_host_rdata(o_host_rdata), .o_state(o_state),
    .o_cycles(o_cycles)
  );

  bip_exec_ctrl #(.NB_CYC(4)) u_dut_sat (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_step(i_step), .i_clear(i_clear),
    .i_instruc(i_instruc), .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
    .i_cpu_wr(i_cpu_wr), .i_cpu_rd(i_cpu_rd), .i_host_req(i_host_req), .i_host_we(i_host_we),
    .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata), .i_ram_rdata(i_ram_rdata),
    .o_cpu_en(s_cpu_en), .o_cpu_clr(s_cpu_clr), .o_ram_addr(s_ram_addr),
    .o_ram_wdata(s_ram_wdata), .o_ram_we(s_ram_we), .o_ram_re(s_ram_re),
    .o_host_ack(s_host_ack), .o_host_rdata(s_host_rdata), .o_state(s_state),
    .o_cycles(s_cycles)
  );

  // RAM model with one-cycle read latency, driven by the main instance.
  always @(posedge i_clk) begin
    if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
    if (o_ram_re) i_ram_rdata <= mem[o_ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    i_rst = 1'b0; i_start = 0; i_step = 0; i_clear = 0; i_instruc = NOP;
    i_cpu_addr = '0; i_cpu_wdata = '0; i_cpu_wr = 0; i_cpu_rd = 0;
    i_host_req = 0; i_host_we = 0; i_host_addr = '0; i_host_wdata = '0;
    i_ram_rdata = '0;

    // reset values
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_state", 32'(o_state), 0);
    chk("rst_cycles", 32'(o_cycles), 0);
    chk("rst_ack", 32'(o_host_ack), 0);
    chk("rst_clr", 32'(o_cpu_clr), 0);
    chk("rst_rdata", 32'(o_host_rdata), 0);
    chk("rst_en", 32'(o_cpu_en), 0);
    chk("rst_we", 32'(o_ram_we), 0);
    chk("rst_re", 32'(o_ram_re), 0);
    @(negedge i_clk); i_rst = 1'b1;

    // run five instructions then HLT
    @(negedge i_clk); i_start = 1; #1;
    chk("idle_en", 32'(o_cpu_en), 0);
    @(negedge i_clk); i_start = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge i_clk);
      #1;
      chk("run_state", 32'(o_state), 1);
      chk("run_en", 32'(o_cpu_en), 1);
    end
    @(negedge i_clk); i_instruc = HLT; #1;
    chk("hlt_en", 32'(o_cpu_en), 0);
    chk("hlt_state_run", 32'(o_state), 1);
    @(negedge i_clk); #1;
    chk("halt_state", 32'(o_state), 3);
    chk("halt_cycles", 32'(o_cycles), 5);
    chk("halt_cycles_sat", 32'(s_cycles), 5);
    i_start = 1; i_step = 1;
    @(negedge i_clk); i_start = 0; i_step = 0; #1;
    chk("halt_ignores_start", 32'(o_state), 3);

    // clear out of HALT
    i_clear = 1; #1;
    chk("clr_not_yet", 32'(o_cpu_clr), 0);
    @(negedge i_clk); i_clear = 0; i_instruc = NOP; #1;
    chk("clr_pulse", 32'(o_cpu_clr), 1);
    chk("clr_state", 32'(o_state), 0);
    chk("clr_cycles", 32'(o_cycles), 0);
    @(negedge i_clk); #1;
    chk("clr_one_cycle", 32'(o_cpu_clr), 0);

    // single step
    i_step = 1;
    @(negedge i_clk); i_step = 0; #1;
    chk("step_state", 32'(o_state), 2);
    chk("step_en", 32'(o_cpu_en), 1);
    @(negedge i_clk); #1;
    chk("step_back_idle", 32'(o_state), 0);
    chk("step_en_off", 32'(o_cpu_en), 0);
    chk("step_cycles", 32'(o_cycles), 1);
    i_clear = 1;
    @(negedge i_clk); i_clear = 0; #1;
    chk("idle_clear_ignored", 32'(o_cpu_clr), 0);
    chk("idle_clear_cycles", 32'(o_cycles), 1);

    // host write then read
    @(negedge i_clk);
    i_host_req = 1; i_host_we = 1; i_host_addr = 11'h010; i_host_wdata = 16'hBEEF; #1;
    chk("hw_we", 32'(o_ram_we), 1);
    chk("hw_addr", 32'(o_ram_addr), 32'h010);
    chk("hw_wdata", 32'(o_ram_wdata), 32'hBEEF);
    chk("hw_ack_early", 32'(o_host_ack), 0);
    @(negedge i_clk); i_host_req = 0; i_host_we = 0; #1;
    chk("hw_ack", 32'(o_host_ack), 1);
    chk("hw_we_off", 32'(o_ram_we), 0);
    @(negedge i_clk); i_host_req = 1; #1;
    chk("hr_re", 32'(o_ram_re), 1);
    chk("hr_we", 32'(o_ram_we), 0);
    @(negedge i_clk); i_host_req = 0; #1;
    chk("hr_ack", 32'(o_host_ack), 1);
    chk("hr_rdata", 32'(o_host_rdata), 32'hBEEF);
    @(negedge i_clk); #1;
    chk("hr_ack_off", 32'(o_host_ack), 0);

    // held request: one access per two cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk); i_host_req = 1; #1;
      chk("held_re", 32'(o_ram_re), (i % 2 == 0) ? 1 : 0);
      chk("held_ack", 32'(o_host_ack), (i % 2 == 1) ? 1 : 0);
    end

    // start and host request together: CPU wins
    @(negedge i_clk); i_start = 1; #1;
    chk("tie_re", 32'(o_ram_re), 0);
    chk("tie_we", 32'(o_ram_we), 0);
    chk("tie_ack", 32'(o_host_ack), 0);

    // request held during RUN: CPU strobes pass, no ack
    @(negedge i_clk); i_start = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge i_clk);
      i_cpu_addr = 11'(256 + i); i_cpu_wdata = 16'(i);
      i_cpu_wr = (i % 2 == 0); i_cpu_rd = (i % 2 == 1); #1;
      chk("runh_ack", 32'(o_host_ack), 0);
      chk("runh_addr", 32'(o_ram_addr), 32'(256 + i));
      chk("runh_we", 32'(o_ram_we), (i % 2 == 0) ? 1 : 0);
      chk("runh_re", 32'(o_ram_re), (i % 2 == 1) ? 1 : 0);
    end
    @(negedge i_clk); i_instruc = HLT; i_cpu_wr = 0; i_cpu_rd = 0; #1;
    chk("runh_hlt_en", 32'(o_cpu_en), 0);
    chk("runh_host_re", 32'(o_ram_re), 1);
    chk("runh_host_addr", 32'(o_ram_addr), 32'h010);
    chk("runh_ack_early", 32'(o_host_ack), 0);
    @(negedge i_clk); i_host_req = 0; #1;
    chk("runh_ack", 32'(o_host_ack), 1);
    chk("runh_rdata", 32'(o_host_rdata), 32'hBEEF);
    chk("runh_state", 32'(o_state), 3);
    chk("runh_cycles", 32'(o_cycles), 21);
    chk("sat_cycles", 32'(s_cycles), 32'hF);

    // reset in the middle of RUN with a pending host request
    i_clear = 1; i_instruc = NOP;
    @(negedge i_clk); i_clear = 0; i_start = 1; i_host_req = 1;
    @(negedge i_clk); i_start = 0;
    @(negedge i_clk); #1;
    chk("mid_run_state", 32'(o_state), 1);
    i_rst = 1'b0; #1;
    chk("arst_state", 32'(o_state), 0);
    chk("arst_cycles", 32'(o_cycles), 0);
    chk("arst_en", 32'(o_cpu_en), 0);
    chk("arst_re", 32'(o_ram_re), 0);
    chk("arst_we", 32'(o_ram_we), 0);
    chk("arst_ack", 32'(o_host_ack), 0);
    chk("arst_rdata", 32'(o_host_rdata), 0);
    @(negedge i_clk); i_host_req = 0; i_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk); #1;
      chk("post_rst_ack", 32'(o_host_ack), 0);
      chk("post_rst_state", 32'(o_state), 0);
    end

    // reset in the cycle a host access is issued
    i_host_req = 1; i_host_we = 0; #1;
    chk("acc_re", 32'(o_ram_re), 1);
    i_rst = 1'b0; i_host_req = 0; #1;
    chk("acc_rst_re", 32'(o_ram_re), 0);
    @(negedge i_clk); i_rst = 1'b1; #1;
    chk("acc_rst_ack", 32'(o_host_ack), 0);
    @(negedge i_clk); #1;
    chk("acc_rst_ack2", 32'(o_host_ack), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
